fall_event_encoder: RTL and testbench
=====================================

# fall_event_encoder

Downstream consumer of the 32-bit sticky falling-edge capture vector. It turns each newly set capture bit into one event carrying the 5-bit bit index. Events go out over a valid/ready stream in round-robin order, so software or a downstream FSM can service one edge at a time. The block also keeps per-bit pending state, a pending-count status output, and an accepted-event counter.

## Interface
Parameters:
- `WIDTH`, 32: capture vector width. Fixed at 32; `IDX_W` is a localparam of 5.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `cap_in` in 32: sticky capture flags from the upstream capture stage. Synchronous to `clk`. A bit rises once per captured fall and returns to 0 only when upstream is reset.
- `evt_valid` out 1: an event is presented.
- `evt_idx` out 5: bit index of the presented event.
- `evt_ready` in 1: consumer accepts the event.
- `pend_cnt` out 6: number of bits currently pending (0..32).
- `evt_cnt` out 16: accepted-event count, saturating.
- `drop_cnt` out 8: merged-event count, saturating (see Configuration).

## Operation
- Internal registers:
  - `seen[31:0]`: edge-detect history of `cap_in`.
  - `pending[31:0]`: events waiting to be sent.
  - `last_idx[4:0]`: index of the last granted event.
  - Output register: `evt_valid`, `evt_idx`.
  - `evt_cnt`, `drop_cnt`.
- Rise detection: `new = cap_in & ~seen`. Every edge sets `seen <= cap_in`. A bit that drops to 0 clears `seen`, so a later rise counts as a new event.
- Pending set: on each edge, `pending |= new`. The bit granted on that edge is cleared in the same update.
- Merge case: a `new` bit whose `pending` bit is already set and not granted this edge is merged. `drop_cnt` increments by 1 per edge in which this happens, not per bit.
- Round-robin grant: search `pending` from `(last_idx+1) mod 32` upward, wrapping after bit 31. The first set bit wins. Searching the registered `pending` gives it one cycle of latency.
- Output load: on an edge where `(!evt_valid || evt_ready)` and `pending != 0`:
  - `evt_idx <= winner`, `evt_valid <= 1`, `last_idx <= winner`.
  - `pending[winner]` is cleared.
- On an edge where `evt_valid && evt_ready` and `pending == 0`: `evt_valid <= 0`.
- While `evt_valid && !evt_ready`, `evt_idx` holds stable and no grant occurs.
- `evt_cnt` increments on every edge with `evt_valid && evt_ready` and saturates at 0xFFFF.
- `pend_cnt` is the combinational popcount of the registered `pending`.

## Timing
- Reset values: `seen`=0, `pending`=0, `last_idx`=31 (the first search starts at bit 0). `evt_valid`=0, `evt_idx`=0, `pend_cnt`=0, `evt_cnt`=0, `drop_cnt`=0.
- Latency: `cap_in[k]` rises before edge E1, so `pending[k]` is set at E1. `evt_valid=1` with `evt_idx=k` follows at E2, provided the output is free and k wins arbitration.
- Throughput: one event per cycle with `evt_ready` held high. Back-to-back accepts reload at the same edge.
- Simultaneous rises of several bits: all go pending in one edge and are granted in round-robin order, one per accepted cycle.
- Bits high when `reset_n` releases: `seen`=0, so each such bit generates an event, at E1 and E2 after release.
- `reset_n` asserted mid-transfer: all state clears immediately and asynchronously. An in-flight event is lost and is not counted.
- Grant and merge on the same bit in the same edge: the bit is granted, and the new rise sets `pending` again. This is not a drop.

## Configuration
- `FALL_EVT_DROP_CNT_EN`:
  - Defined: the `drop_cnt` logic is built as described. It is an 8-bit counter that saturates at 0xFF.
  - Undefined: the counter is not synthesized. `drop_cnt` is tied to 0, and the port list is unchanged.

## Test plan
- Reset, then `cap_in`=0x00000001 with `evt_ready`=1 → `evt_valid` for one cycle, `evt_idx`=0, 2 edges after the rise; `evt_cnt`=1, `pend_cnt` returns to 0.
- `cap_in`=0x80000005 in one cycle, `evt_ready`=1 → indices 0, 2, 31 on consecutive cycles; `pend_cnt` reads 3 then 2, 1, 0; `evt_cnt`=3.
- `evt_ready`=0 with `cap_in`=0x00000006 → `evt_idx`=1 held stable for 5 cycles, `pend_cnt`=1. Release ready → idx 2 on the next cycle.
- Wrap: after a grant of idx 30, `pending` = bits 0 and 31 → grant 31 then 0.
- With `evt_ready`=0 and bit 3 pending, pulse `cap_in[3]` 1→0→1 → `drop_cnt`=1 with the macro, 0 without; only one idx-3 event is emitted.
- Assert `reset_n` while `evt_valid`=1 and `pending`=0x0000F000 → all outputs 0 immediately. Release with `cap_in`=0x00000010 → event idx 4.

Source files
------------

// File: rtl/fall_event_encoder_if.sv
// fall_event_encoder_if
// Valid/ready event stream carrying the 5-bit index of a captured falling edge.
// The encoder drives through the master modport and the consumer uses the slave modport.
interface fall_event_encoder_if;
    logic       evt_valid;
    logic [4:0] evt_idx;
    logic       evt_ready;

    modport master (
        output evt_valid,
        output evt_idx,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_idx,
        output evt_ready
    );
endinterface

// File: rtl/fall_event_encoder.sv
// fall_event_encoder
// Turns each newly set bit of the sticky 32-bit falling-edge capture vector into
// one event that carries the bit index. Events leave on a valid/ready stream in
// round-robin order. The block also reports a pending-bit popcount, a saturating
// accepted-event counter and a saturating merged-event counter.
// Optional feature macro: FALL_EVT_DROP_CNT_EN. When it is defined, the drop
// counter is built. When it is undefined, drop_cnt is tied to zero.
module fall_event_encoder #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WIDTH-1:0]     cap_in,
    fall_event_encoder_if.master evt,
    output logic [5:0]           pend_cnt,
    output logic [15:0]          evt_cnt,
    output logic [7:0]           drop_cnt
);
    localparam int IDX_W = 5;

    logic [WIDTH-1:0] seen;
    logic [WIDTH-1:0] pending;
    logic [IDX_W-1:0] last_idx;
    logic             valid_q;
    logic [IDX_W-1:0] idx_q;

    logic [WIDTH-1:0] new_bits;
    logic [WIDTH-1:0] grant_mask;
    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] cand;
    logic             found;
    logic             load;
    logic             accept;

    assign new_bits = cap_in & ~seen;
    assign accept   = valid_q & evt.evt_ready;
    assign load     = (~valid_q | evt.evt_ready) & (|pending);

    assign evt.evt_valid = valid_q;
    assign evt.evt_idx   = idx_q;

    // Round-robin search of the registered pending vector, starting one past the last grant
    always_comb begin
        winner = '0;
        cand   = '0;
        found  = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            cand = last_idx + IDX_W'(i + 1);
            if (!found && pending[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    // One-hot mask of the bit granted on this edge, empty when the output cannot load
    always_comb begin
        grant_mask = '0;
        if (load) begin
            grant_mask[winner] = 1'b1;
        end
    end

    // Popcount of the pending bits for the status output
    always_comb begin
        pend_cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pend_cnt = pend_cnt + {{IDX_W{1'b0}}, pending[i]};
        end
    end

    // Edge history and pending set: a granted bit clears, and a fresh rise on it sets it again
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seen    <= '0;
            pending <= '0;
        end else begin
            seen    <= cap_in;
            pending <= (pending & ~grant_mask) | new_bits;
        end
    end

    // Output register: reload on a free or accepted slot, and drop valid once nothing is left
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q  <= 1'b0;
            idx_q    <= '0;
            last_idx <= '1;
        end else if (load) begin
            valid_q  <= 1'b1;
            idx_q    <= winner;
            last_idx <= winner;
        end else if (accept) begin
            valid_q  <= 1'b0;
        end
    end

    // Saturating count of events taken by the consumer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            evt_cnt <= '0;
        end else if (accept && (evt_cnt != 16'hFFFF)) begin
            evt_cnt <= evt_cnt + 16'd1;
        end
    end

`ifdef FALL_EVT_DROP_CNT_EN
    logic merge;

    assign merge = |(new_bits & pending & ~grant_mask);

    // Saturating count of edges on which a new rise folded into an already pending bit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_cnt <= '0;
        end else if (merge && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end
`else
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_fall_event_encoder.sv
// tb_fall_event_encoder
// Directed bench for fall_event_encoder. It uses hand-computed expected values
// for the latency, round-robin order, back-pressure, wrap, merge and reset cases.
module tb_fall_event_encoder;
    logic        clk;
    logic        reset_n;
    logic [31:0] cap_in;
    logic [5:0]  pend_cnt;
    logic [15:0] evt_cnt;
    logic [7:0]  drop_cnt;

    int tests_run;
    int tests_failed;

    fall_event_encoder_if evt ();

    fall_event_encoder #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .cap_in   (cap_in),
        .evt      (evt.master),
        .pend_cnt (pend_cnt),
        .evt_cnt  (evt_cnt),
        .drop_cnt (drop_cnt)
    );

    // Free-running clock with a 10-unit period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the sequence ever stalls
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drive the inputs, then advance past one rising edge so the outputs can be sampled
    task automatic applyStimulus(input logic [31:0] cap, input logic ready);
        cap_in        = cap;
        evt.evt_ready = ready;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        reset_n       = 1'b0;
        cap_in        = '0;
        evt.evt_ready = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        logic [7:0] exp_drop;
        tests_run    = 0;
        tests_failed = 0;
        reset_n      = 1'b1;
        cap_in       = '0;
        evt.evt_ready = 1'b0;
`ifdef FALL_EVT_DROP_CNT_EN
        exp_drop = 8'd1;
`else
        exp_drop = 8'd0;
`endif

        // Reset state
        doReset();
        checkOutput("rst_valid", {31'd0, evt.evt_valid}, 32'd0);
        checkOutput("rst_idx", {27'd0, evt.evt_idx}, 32'd0);
        checkOutput("rst_pend", {26'd0, pend_cnt}, 32'd0);
        checkOutput("rst_evtcnt", {16'd0, evt_cnt}, 32'd0);
        checkOutput("rst_drop", {24'd0, drop_cnt}, 32'd0);

        // Single rise: two-edge latency, one-cycle valid
        applyStimulus(32'h0000_0001, 1'b1);
        checkOutput("t1_e1_valid", {31'd0, evt.evt_valid}, 32'd0);
        checkOutput("t1_e1_pend", {26'd0, pend_cnt}, 32'd1);
        applyStimulus(32'h0000_0001, 1'b1);
        checkOutput("t1_e2_valid", {31'd0, evt.evt_valid}, 32'd1);
        checkOutput("t1_e2_idx", {27'd0, evt.evt_idx}, 32'd0);
        checkOutput("t1_e2_pend", {26'd0, pend_cnt}, 32'd0);
        applyStimulus(32'h0000_0001, 1'b1);
        checkOutput("t1_e3_valid", {31'd0, evt.evt_valid}, 32'd0);
        checkOutput("t1_e3_evtcnt", {16'd0, evt_cnt}, 32'd1);

        // Simultaneous rises granted in round-robin order at full throughput
        doReset();
        applyStimulus(32'h8000_0005, 1'b1);
        checkOutput("t2_pend3", {26'd0, pend_cnt}, 32'd3);
        applyStimulus(32'h8000_0005, 1'b1);
        checkOutput("t2_idx0", {27'd0, evt.evt_idx}, 32'd0);
        checkOutput("t2_pend2", {26'd0, pend_cnt}, 32'd2);
        applyStimulus(32'h8000_0005, 1'b1);
        checkOutput("t2_idx2", {27'd0, evt.evt_idx}, 32'd2);
        checkOutput("t2_pend1", {26'd0, pend_cnt}, 32'd1);
        applyStimulus(32'h8000_0005, 1'b1);
        checkOutput("t2_idx31", {27'd0, evt.evt_idx}, 32'd31);
        checkOutput("t2_valid31", {31'd0, evt.evt_valid}, 32'd1);
        checkOutput("t2_pend0", {26'd0, pend_cnt}, 32'd0);
        applyStimulus(32'h8000_0005, 1'b1);
        checkOutput("t2_valid_end", {31'd0, evt.evt_valid}, 32'd0);
        checkOutput("t2_evtcnt", {16'd0, evt_cnt}, 32'd3);

        // Back-pressure holds the index stable
        doReset();
        applyStimulus(32'h0000_0006, 1'b0);
        applyStimulus(32'h0000_0006, 1'b0);
        for (int i = 0; i < 5; i++) begin
            checkOutput("t3_hold_valid", {31'd0, evt.evt_valid}, 32'd1);
            checkOutput("t3_hold_idx", {27'd0, evt.evt_idx}, 32'd1);
            checkOutput("t3_hold_pend", {26'd0, pend_cnt}, 32'd1);
            applyStimulus(32'h0000_0006, 1'b0);
        end
        applyStimulus(32'h0000_0006, 1'b1);
        checkOutput("t3_rel_idx", {27'd0, evt.evt_idx}, 32'd2);
        checkOutput("t3_rel_evtcnt", {16'd0, evt_cnt}, 32'd1);
        applyStimulus(32'h0000_0006, 1'b1);
        checkOutput("t3_end_valid", {31'd0, evt.evt_valid}, 32'd0);
        checkOutput("t3_end_evtcnt", {16'd0, evt_cnt}, 32'd2);

        // Wrap-around after a grant of index 30
        doReset();
        applyStimulus(32'h4000_0000, 1'b0);
        applyStimulus(32'h4000_0000, 1'b0);
        checkOutput("t4_idx30", {27'd0, evt.evt_idx}, 32'd30);
        applyStimulus(32'hC000_0001, 1'b0);
        checkOutput("t4_pend2", {26'd0, pend_cnt}, 32'd2);
        applyStimulus(32'hC000_0001, 1'b1);
        checkOutput("t4_idx31", {27'd0, evt.evt_idx}, 32'd31);
        applyStimulus(32'hC000_0001, 1'b1);
        checkOutput("t4_idx0", {27'd0, evt.evt_idx}, 32'd0);
        checkOutput("t4_valid0", {31'd0, evt.evt_valid}, 32'd1);

        // Merge: a second rise on a bit that is still pending
        doReset();
        applyStimulus(32'h0000_0001, 1'b0);
        applyStimulus(32'h0000_0001, 1'b0);
        applyStimulus(32'h0000_0009, 1'b0);
        checkOutput("t5_pend_b3", {26'd0, pend_cnt}, 32'd1);
        applyStimulus(32'h0000_0001, 1'b0);
        applyStimulus(32'h0000_0009, 1'b0);
        checkOutput("t5_drop", {24'd0, drop_cnt}, {24'd0, exp_drop});
        checkOutput("t5_pend_merged", {26'd0, pend_cnt}, 32'd1);
        checkOutput("t5_hold_idx0", {27'd0, evt.evt_idx}, 32'd0);
        applyStimulus(32'h0000_0009, 1'b1);
        checkOutput("t5_idx3", {27'd0, evt.evt_idx}, 32'd3);
        checkOutput("t5_pend_empty", {26'd0, pend_cnt}, 32'd0);
        applyStimulus(32'h0000_0009, 1'b1);
        checkOutput("t5_valid_end", {31'd0, evt.evt_valid}, 32'd0);
        applyStimulus(32'h0000_0009, 1'b1);
        checkOutput("t5_single_evt", {16'd0, evt_cnt}, 32'd2);
        checkOutput("t5_drop_final", {24'd0, drop_cnt}, {24'd0, exp_drop});

        // Asynchronous reset mid-transfer, then events for bits high at release
        doReset();
        applyStimulus(32'h0000_0001, 1'b0);
        applyStimulus(32'h0000_0001, 1'b0);
        applyStimulus(32'h0000_F001, 1'b0);
        checkOutput("t6_pre_valid", {31'd0, evt.evt_valid}, 32'd1);
        checkOutput("t6_pre_pend", {26'd0, pend_cnt}, 32'd4);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("t6_async_valid", {31'd0, evt.evt_valid}, 32'd0);
        checkOutput("t6_async_idx", {27'd0, evt.evt_idx}, 32'd0);
        checkOutput("t6_async_pend", {26'd0, pend_cnt}, 32'd0);
        checkOutput("t6_async_evtcnt", {16'd0, evt_cnt}, 32'd0);
        cap_in = 32'h0000_0010;
        #2;
        reset_n = 1'b1;
        applyStimulus(32'h0000_0010, 1'b1);
        checkOutput("t6_e1_pend", {26'd0, pend_cnt}, 32'd1);
        checkOutput("t6_e1_valid", {31'd0, evt.evt_valid}, 32'd0);
        applyStimulus(32'h0000_0010, 1'b1);
        checkOutput("t6_e2_valid", {31'd0, evt.evt_valid}, 32'd1);
        checkOutput("t6_e2_idx", {27'd0, evt.evt_idx}, 32'd4);
        checkOutput("t6_e2_evtcnt", {16'd0, evt_cnt}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
